// File: rtl/reg_bank.sv
// reg_bank: control/status register bank behind a req/ack bus.
// Registers: CTRL (RW), STAT (W1C, set by hw_evt), WCNT (RO write counter),
// SCRATCH (RW). Addresses >= 4 are unmapped and flag err.
module reg_bank #(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 2,
  parameter logic [31:0] CTRL_RST = 32'h05
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic [DW-1:0] ctrl_out,
  input  logic [DW-1:0] hw_evt,
  output logic          irq
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACKS = 1'b1;

  localparam logic [1:0] A_CTRL    = 2'd0;
  localparam logic [1:0] A_STAT    = 2'd1;
  localparam logic [1:0] A_WCNT    = 2'd2;
  localparam logic [1:0] A_SCRATCH = 2'd3;

  logic [0:0]    state_q;
  logic [0:0]    state_d;
  logic          accept;
  logic          mapped;
  logic [1:0]    sel;
  logic          wr_hit;
  logic [DW-1:0] stat_q;
  logic [DW-1:0] stat_d;
  logic [DW-1:0] stat_clr;
  logic [DW-1:0] wcnt_q;
  logic [DW-1:0] scratch_q;
  logic [DW-1:0] rd_mux;

  // Transaction state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: accept in IDLE, ACK lasts exactly one cycle and ignores req
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACKS;
          accept  = 1'b1;
        end
      end
      ACKS:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address decode and write-side strobes
  always_comb begin
    mapped   = (32'(addr) < 32'd4);
    sel      = addr[1:0];
    wr_hit   = accept && wr && mapped;
    stat_clr = (wr_hit && (sel == A_STAT)) ? wdata : '0;
    // Event set is OR-ed in after the clear so a simultaneous set wins
    stat_d   = (stat_q & ~stat_clr) | hw_evt;
  end

  // Read mux returns register values as held before the accept edge
  always_comb begin
    rd_mux = '0;
    case (sel)
      A_CTRL:    rd_mux = ctrl_out;
      A_STAT:    rd_mux = stat_q;
      A_WCNT:    rd_mux = wcnt_q;
      A_SCRATCH: rd_mux = scratch_q;
      default:   rd_mux = '0;
    endcase
  end

  // Registers, bus response and interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      ack       <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      ctrl_out  <= DW'(CTRL_RST);
      stat_q    <= '0;
      wcnt_q    <= '0;
      scratch_q <= '0;
      irq       <= 1'b0;
    end else begin
      ack    <= accept;
      err    <= accept && !mapped;
      rdata  <= (accept && !wr && mapped) ? rd_mux : '0;
      stat_q <= stat_d;
      irq    <= |stat_d;
      if (wr_hit) begin
        wcnt_q <= wcnt_q + DW'(1);
        if (sel == A_CTRL)    ctrl_out  <= wdata;
        if (sel == A_SCRATCH) scratch_q <= wdata;
      end
    end
  end

endmodule
